// File: rtl/rv32_pkg.sv
// Shared RV32I load/store encodings and the LSU state type.
package rv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/ack bus between the MEM-stage LSU and the data memory.
interface mem_stage_lsu_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / replicated data, load extract and extend.
module lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        is_store,
    input  logic [31:0] wd,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        bad
);

    logic        [7:0]  lbyte;
    logic        [15:0] lhalf;
    logic signed [7:0]  lbyte_s;
    logic signed [15:0] lhalf_s;

    always_comb begin
        case (funct3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = addr_lo[0];
            F3_W:        bad = (addr_lo != 2'b00);
            default:     bad = 1'b1;
        endcase
    end

    // Loads always fetch the full word; only stores narrow the enables.
    always_comb begin
        be    = 4'b1111;
        wdata = wd;
        if (is_store) begin
            case (funct3)
                F3_B, F3_BU: begin
                    be    = 4'b0001 << addr_lo;
                    wdata = {4{wd[7:0]}};
                end
                F3_H, F3_HU: begin
                    be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{wd[15:0]}};
                end
                default: begin
                    be    = 4'b1111;
                    wdata = wd;
                end
            endcase
        end
    end

    always_comb begin
        lbyte   = rdata[{addr_lo, 3'b000} +: 8];
        lhalf   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        lbyte_s = lbyte;
        lhalf_s = lhalf;
        case (funct3)
            F3_B:    ldata = 32'(lbyte_s);
            F3_BU:   ldata = {24'b0, lbyte};
            F3_H:    ldata = 32'(lhalf_s);
            F3_HU:   ldata = {16'b0, lhalf};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack bus FSM with timeout, load formatting and pipeline stall.
module mem_stage_lsu
    import rv32_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           alu_result_m,
    input  logic [31:0]           write_data_m,
    input  logic [2:0]            funct3_m,
    input  logic                  mem_read_m,
    input  logic                  mem_write_m,
    mem_stage_lsu_if.master       bus,
    output logic [31:0]           read_data_m,
    output logic                  stall_m,
    output logic                  misaligned_m,
    output logic                  bus_err_m
);

    lsu_state_t        state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              access;
    logic              bad;
    logic              timeout;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic [31:0]       ldata_c;

    assign access  = mem_read_m | mem_write_m;
    assign timeout = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    lsu_align u_align (
        .funct3   (funct3_m),
        .addr_lo  (alu_result_m[1:0]),
        .is_store (mem_write_m),
        .wd       (write_data_m),
        .rdata    (bus.dmem_rdata),
        .be       (be_c),
        .wdata    (wdata_c),
        .ldata    (ldata_c),
        .bad      (bad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (access) state_nx = bad ? DONE : REQ;
            REQ:     if (bus.dmem_ack || timeout) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Reset forces the pipeline free even while EX/MEM still presents an access.
    always_comb begin
        stall_m = !rst && (((state == IDLE) && access) || (state == REQ));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            bus.dmem_req   <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_be    <= '0;
            bus.dmem_wdata <= '0;
            read_data_m    <= '0;
            misaligned_m   <= 1'b0;
            bus_err_m      <= 1'b0;
        end else begin
            misaligned_m <= 1'b0;
            bus_err_m    <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && bad) begin
                        misaligned_m <= 1'b1;
                        read_data_m  <= '0;
                    end else if (access) begin
                        bus.dmem_req   <= 1'b1;
                        bus.dmem_we    <= mem_write_m;
                        bus.dmem_addr  <= {alu_result_m[31:2], 2'b00};
                        bus.dmem_be    <= be_c;
                        bus.dmem_wdata <= wdata_c;
                    end
                end
                REQ: begin
                    // An ack on the timeout cycle still completes the access cleanly.
                    if (bus.dmem_ack) begin
                        bus.dmem_req <= 1'b0;
                        cnt          <= '0;
                        read_data_m  <= bus.dmem_we ? 32'b0 : ldata_c;
                    end else if (timeout) begin
                        bus.dmem_req <= 1'b0;
                        cnt          <= '0;
                        read_data_m  <= '0;
                        bus_err_m    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Table-driven bench for mem_stage_lsu with a scoreboard of expected completions.
module tb_mem_stage_lsu;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic [31:0] alu_result_m;
    logic [31:0] write_data_m;
    logic [2:0]  funct3_m;
    logic        mem_read_m;
    logic        mem_write_m;
    logic [31:0] read_data_m;
    logic        stall_m;
    logic        misaligned_m;
    logic        bus_err_m;

    mem_stage_lsu_if bus ();

    mem_stage_lsu #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_result_m (alu_result_m),
        .write_data_m (write_data_m),
        .funct3_m     (funct3_m),
        .mem_read_m   (mem_read_m),
        .mem_write_m  (mem_write_m),
        .bus          (bus),
        .read_data_m  (read_data_m),
        .stall_m      (stall_m),
        .misaligned_m (misaligned_m),
        .bus_err_m    (bus_err_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          dly;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rd;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic        err;
        int          reqc;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   total = 0;
    int   nbad  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic is_st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rdata, input int dly,
                                input logic [3:0] e_be, input logic [31:0] e_wdata,
                                input logic [31:0] e_rd, input logic e_mis);
        vec_t v;
        v.is_st = is_st; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata; v.dly = dly;
        v.e_be = e_be; v.e_wdata = e_wdata; v.e_rd = e_rd; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic idle_inputs();
        mem_read_m     = 1'b0;
        mem_write_m    = 1'b0;
        funct3_m       = 3'b000;
        alu_result_m   = 32'h0;
        write_data_m   = 32'h0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h0;
    endtask

    // Called on a falling edge; returns on the falling edge after the DONE cycle.
    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   reqc;
        bit   done;
        bit   ack_now;
        mem_read_m   = !v.is_st;
        mem_write_m  = v.is_st;
        funct3_m     = v.f3;
        alu_result_m = v.addr;
        write_data_m = v.wd;
        bus.dmem_ack = 1'b0;
        e.rd   = v.e_rd;
        e.mis  = v.e_mis;
        e.err  = !v.e_mis && (v.dly >= TO);
        e.reqc = v.e_mis ? 0 : ((v.dly >= TO) ? TO : v.dly + 1);
        sbq.push_back(e);
        #1;
        chk($sformatf("v%0d stall_idle", idx), stall_m, 1'b1);
        reqc = 0;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (!stall_m) begin
                done = 1;
            end else begin
                if (reqc == 0) begin
                    chk($sformatf("v%0d req", idx), bus.dmem_req, 1'b1);
                    chk($sformatf("v%0d we", idx), bus.dmem_we, v.is_st);
                    chk($sformatf("v%0d addr", idx), bus.dmem_addr, v.addr & ~32'h3);
                    chk($sformatf("v%0d be", idx), bus.dmem_be, v.e_be);
                    if (v.is_st) chk($sformatf("v%0d wdata", idx), bus.dmem_wdata, v.e_wdata);
                end else if (!bus.dmem_req) begin
                    chk($sformatf("v%0d req_held", idx), bus.dmem_req, 1'b1);
                end
                ack_now        = (reqc == v.dly);
                bus.dmem_ack   = ack_now;
                bus.dmem_rdata = ack_now ? v.rdata : 32'h5A5A5A5A;
                reqc++;
            end
        end
        if (!done) begin
            total++;
            nbad++;
            $display("FAIL v%0d done_wait: got no DONE within 20 cycles want DONE", idx);
            void'(sbq.pop_front());
        end else begin
            e = sbq.pop_front();
            chk($sformatf("v%0d read_data", idx), read_data_m, e.rd);
            chk($sformatf("v%0d misaligned", idx), misaligned_m, e.mis);
            chk($sformatf("v%0d bus_err", idx), bus_err_m, e.err);
            chk($sformatf("v%0d req_cycles", idx), reqc, e.reqc);
            chk($sformatf("v%0d req_dropped", idx), bus.dmem_req, 1'b0);
        end
        idle_inputs();
        @(negedge clk);
        chk($sformatf("v%0d flags_clear", idx), {misaligned_m, bus_err_m, stall_m}, 3'b000);
    endtask

    initial begin
        // is_st f3 addr wd rdata dly be wdata rd mis
        vecs.push_back(mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 4'b1111, 32'hDEADBEEF, 32'h0,        0));
        vecs.push_back(mk(0, 3'b000, 32'h203, 32'h0,        32'h80FF1234, 2, 4'b1111, 32'h0,        32'hFFFFFF80, 0));
        vecs.push_back(mk(0, 3'b100, 32'h203, 32'h0,        32'h80FF1234, 2, 4'b1111, 32'h0,        32'h00000080, 0));
        vecs.push_back(mk(1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0,        1, 4'b1100, 32'hABCDABCD, 32'h0,        0));
        vecs.push_back(mk(0, 3'b101, 32'h102, 32'h0,        32'hABCD0000, 0, 4'b1111, 32'h0,        32'h0000ABCD, 0));
        vecs.push_back(mk(0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1));
        vecs.push_back(mk(0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1));
        vecs.push_back(mk(0, 3'b001, 32'h100, 32'h0,        32'h12348001, 1, 4'b1111, 32'h0,        32'hFFFF8001, 0));
        vecs.push_back(mk(1, 3'b000, 32'h101, 32'h000000A5, 32'h0,        0, 4'b0010, 32'hA5A5A5A5, 32'h0,        0));
        vecs.push_back(mk(0, 3'b000, 32'h200, 32'h0,        32'h0000007F, 0, 4'b1111, 32'h0,        32'h0000007F, 0));
        vecs.push_back(mk(1, 3'b001, 32'h101, 32'h1234,     32'h0,        0, 4'b0000, 32'h0,        32'h0,        1));
        vecs.push_back(mk(0, 3'b010, 32'h304, 32'h0,        32'hCAFEF00D, 3, 4'b1111, 32'h0,        32'hCAFEF00D, 0));
        vecs.push_back(mk(0, 3'b010, 32'h300, 32'h0,        32'h0,       99, 4'b1111, 32'h0,        32'h0,        0));
        vecs.push_back(mk(1, 3'b110, 32'h100, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1));

        // Reset held with an access presented on the inputs.
        rst = 1'b1;
        idle_inputs();
        mem_read_m   = 1'b1;
        funct3_m     = 3'b010;
        alu_result_m = 32'h100;
        @(negedge clk);
        @(negedge clk);
        chk("rst stall", stall_m, 1'b0);
        chk("rst req", bus.dmem_req, 1'b0);
        chk("rst regs", {bus.dmem_we, bus.dmem_be, misaligned_m, bus_err_m}, 7'b0);
        chk("rst addr", bus.dmem_addr, 32'h0);
        chk("rst wdata", bus.dmem_wdata, 32'h0);
        chk("rst read_data", read_data_m, 32'h0);
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        chk("idle stall", stall_m, 1'b0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset in the middle of a request.
        mem_read_m   = 1'b1;
        funct3_m     = 3'b010;
        alu_result_m = 32'h400;
        @(negedge clk);
        chk("mid req_up", bus.dmem_req, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid req_drop", bus.dmem_req, 1'b0);
        chk("mid stall_drop", stall_m, 1'b0);
        @(negedge clk);
        idle_inputs();
        rst            = 1'b0;
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("late_ack req", bus.dmem_req, 1'b0);
        chk("late_ack stall", stall_m, 1'b0);
        chk("late_ack read_data", read_data_m, 32'h0);
        chk("late_ack flags", {misaligned_m, bus_err_m}, 2'b00);
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        run_vec(mk(0, 3'b010, 32'h408, 32'h0, 32'h01234567, 1, 4'b1111, 32'h0, 32'h01234567, 0), 100);

        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end

endmodule
